// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI opcodes, frame widths and initiator state encoding
package spi_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_CMD   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_WAIT  = 3'd4,
    ST_RECV  = 3'd5,
    ST_GAP   = 3'd6
  } state_t;

endpackage

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI initiator framing RAM commands onto SS_n/MOSI and collecting MISO read data
module spi_master
  import spi_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int GAP    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy
);

  // Last count value of each timed state; one shared counter restarts at every state change.
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] RECV_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = (RD_LAT > 0) ? CNT_W'(RD_LAT - 1) : '0;
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);

  state_t              state;
  state_t              next_state;
  logic [CNT_W-1:0]    cnt;
  logic [FRAME_W-1:0]  tx_shift;
  logic [1:0]          op;
  logic [DATA_W-1:0]   rx_shift;
  logic [DATA_W-1:0]   rx_next;
  logic                accept;

  assign accept = cmd_valid && cmd_ready;

  // State register; reset forces IDLE so SS_n rises without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and pin outputs, all decoded from the current state.
  always_comb begin
    next_state = state;
    SS_n       = 1'b0;
    MOSI       = 1'b0;
    busy       = 1'b1;
    cmd_ready  = 1'b0;
    case (state)
      ST_IDLE: begin
        SS_n      = 1'b1;
        busy      = 1'b0;
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          next_state = ST_START;
        end
      end
      ST_START: begin
        next_state = ST_CMD;
      end
      ST_CMD: begin
        MOSI       = op[1];
        next_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        MOSI = tx_shift[FRAME_W-1];
        if (cnt == SHIFT_LAST) begin
          if (op == OP_RD_DATA) begin
            next_state = (RD_LAT > 0) ? ST_WAIT : ST_RECV;
          end else begin
            next_state = ST_GAP;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == WAIT_LAST) begin
          next_state = ST_RECV;
        end
      end
      ST_RECV: begin
        if (cnt == RECV_LAST) begin
          next_state = ST_GAP;
        end
      end
      ST_GAP: begin
        SS_n = 1'b1;
        if (cnt == GAP_LAST) begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Current RECV sample merged into the partial byte at its LSB-first position.
  always_comb begin
    rx_next              = rx_shift;
    rx_next[cnt[2:0]]    = MISO;
  end

  // Datapath: command latch, TX shifter, RX assembly, response pulse and state counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      tx_shift  <= '0;
      op        <= '0;
      rx_shift  <= '0;
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if ((next_state != state) || (state == ST_IDLE)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (accept) begin
        tx_shift <= {cmd_op, cmd_data};
        op       <= cmd_op;
      end else if (state == ST_SHIFT) begin
        tx_shift <= {tx_shift[FRAME_W-2:0], 1'b0};
      end
      if (state == ST_RECV) begin
        rx_shift <= rx_next;
        if (cnt == RECV_LAST) begin
          rsp_data  <= rx_next;
          rsp_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - randomized scoreboard bench for spi_master with a slave-side MISO model
module tb_spi_master;

  localparam int RD_LAT = 2;
  localparam int GAP    = 1;

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
  } frame_t;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;

  int total;
  int bad;
  int cyc;
  int sent;
  int frames_seen;
  bit mon_en;

  frame_t     exp_q[$];
  logic [7:0] exp_rsp_q[$];
  logic [7:0] miso_q[$];
  int         start_q[$];

  spi_master #(.RD_LAT(RD_LAT), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
  endtask

  // Reference: the SS_n-low MOSI stream is a select bit, the path bit, the 10-bit frame
  // MSB first, then RD_LAT wait bits and 8 receive bits (all zero) for a read-data command.
  task automatic model_frame(input logic [1:0] op, input logic [7:0] d,
                             output logic [63:0] bits, output int len);
    logic [9:0] f;
    f    = {op, d};
    bits = '0;
    len  = 0;
    bits = {bits[62:0], 1'b0};  len++;
    bits = {bits[62:0], op[1]}; len++;
    for (int k = 9; k >= 0; k--) begin
      bits = {bits[62:0], f[k]};
      len++;
    end
    if (op == 2'b11) begin
      for (int k = 0; k < RD_LAT + 8; k++) begin
        bits = {bits[62:0], 1'b0};
        len++;
      end
    end
  endtask

  // Frame monitor: captures each SS_n-low window and compares it with the oldest expected frame.
  initial begin
    bit          in_frame;
    bit          ctl_bad;
    int          len;
    int          exp_len;
    logic [63:0] bits;
    logic [63:0] exp_bits;
    frame_t      e;
    in_frame = 0;
    ctl_bad  = 0;
    len      = 0;
    bits     = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        in_frame = 0;
      end else if (SS_n === 1'b0) begin
        if (!in_frame) begin
          in_frame = 1;
          len      = 0;
          bits     = '0;
          ctl_bad  = 0;
          start_q.push_back(cyc);
        end
        bits = {bits[62:0], MOSI};
        len++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) ctl_bad = 1;
      end else if (in_frame) begin
        in_frame = 0;
        frames_seen++;
        if (exp_q.size() == 0) begin
          fail_now("frame_extra");
        end else begin
          e = exp_q.pop_front();
          model_frame(e.op, e.data, exp_bits, exp_len);
          check("frame_len", 64'(len), 64'(exp_len));
          check("frame_mosi", bits, exp_bits);
          check("frame_ready_busy", 64'(ctl_bad), 64'(0));
          check("rsp_in_first_gap", 64'(rsp_valid), 64'(e.op == 2'b11));
        end
      end
    end
  end

  // Response monitor: every rsp_valid pulse must match the next expected read byte.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        if (exp_rsp_q.size() == 0) begin
          fail_now("rsp_extra");
        end else begin
          e = exp_rsp_q.pop_front();
          check("rsp_data", 64'(rsp_data), 64'(e));
        end
      end
    end
  end

  // Slave model: decodes the opcode off MOSI and serves the queued byte LSB first in the
  // receive window; every other cycle carries random noise that must be ignored.
  initial begin
    int         pos;
    bit         rd;
    logic [7:0] b;
    logic [1:0] opd;
    pos  = 0;
    rd   = 0;
    b    = '0;
    opd  = '0;
    MISO = 1'b0;
    forever begin
      @(negedge clk);
      if (SS_n !== 1'b0) begin
        pos  = 0;
        rd   = 0;
        MISO = 1'($urandom);
      end else begin
        if (pos == 2) opd[1] = MOSI;
        if (pos == 3) begin
          opd[0] = MOSI;
          rd     = (opd == 2'b11);
          if (rd) b = (miso_q.size() != 0) ? miso_q.pop_front() : 8'($urandom);
        end
        if (rd && pos >= 12 + RD_LAT && pos < 20 + RD_LAT) MISO = b[pos - 12 - RD_LAT];
        else MISO = 1'($urandom);
        pos++;
      end
    end
  end

  // Present a command and hold it until accepted; returns on the negedge after acceptance.
  task automatic send(input logic [1:0] op, input logic [7:0] d, input logic [7:0] b);
    int     w;
    frame_t f;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      fail_now("accept_timeout");
    end else if (mon_en) begin
      f.op   = op;
      f.data = d;
      exp_q.push_back(f);
      sent++;
      if (op == 2'b11) begin
        exp_rsp_q.push_back(b);
        miso_q.push_back(b);
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int w;
    cmd_valid = 1'b0;
    w = 0;
    while ((exp_q.size() != 0 || exp_rsp_q.size() != 0 || busy !== 1'b0) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 1000) fail_now("drain_timeout");
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic [1:0] op;
    total       = 0;
    bad         = 0;
    sent        = 0;
    frames_seen = 0;
    mon_en      = 0;
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = '0;
    cmd_data    = '0;

    repeat (3) @(negedge clk);
    check("rst_ss_n", 64'(SS_n), 64'(1));
    check("rst_mosi", 64'(MOSI), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_data", 64'(rsp_data), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Abort a read-data frame at receive bit 3 with an asynchronous reset.
    send(2'b11, 8'h00, 8'hFF);
    cmd_valid = 1'b0;
    repeat (12 + RD_LAT + 3) @(negedge clk);
    check("abort_ss_low_before", 64'(SS_n), 64'(0));
    #2 rst_n = 1'b0;
    #1;
    check("abort_ss_n_async", 64'(SS_n), 64'(1));
    check("abort_rsp_valid", 64'(rsp_valid), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_cmd_ready", 64'(cmd_ready), 64'(1));
    check("abort_rsp_data", 64'(rsp_data), 64'(0));
    repeat (30) @(negedge clk);

    mon_en = 1;
    repeat (2) @(negedge clk);

    // Directed: write address, read address/data pair, LSB-first capture.
    send(2'b00, 8'h5A, 8'h00);
    cmd_valid = 1'b0;
    drain();
    send(2'b10, 8'h3C, 8'h00);
    send(2'b11, 8'h00, 8'hA7);
    cmd_valid = 1'b0;
    drain();
    send(2'b11, 8'h00, 8'h81);
    cmd_valid = 1'b0;
    drain();

    // Inputs toggled while busy must not disturb the latched frame or cause an accept.
    send(2'b00, 8'hC3, 8'h00);
    repeat (10) begin
      cmd_valid = 1'($urandom);
      cmd_op    = 2'($urandom);
      cmd_data  = 8'($urandom);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    drain();

    // Back-to-back writes with cmd_valid held high.
    n0 = start_q.size();
    send(2'b00, 8'h11, 8'h00);
    send(2'b01, 8'h22, 8'h00);
    send(2'b00, 8'h33, 8'h00);
    cmd_valid = 1'b0;
    drain();
    if (start_q.size() >= n0 + 3) begin
      check("b2b_spacing_1", 64'(start_q[n0 + 1] - start_q[n0]), 64'(1 + 12 + GAP));
      check("b2b_spacing_2", 64'(start_q[n0 + 2] - start_q[n0 + 1]), 64'(1 + 12 + GAP));
    end else begin
      fail_now("b2b_frames_missing");
    end

    // Randomized command mix with random idle spacing.
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      send(op, 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        cmd_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    cmd_valid = 1'b0;
    drain();

    check("frame_count", 64'(frames_seen), 64'(sent));
    check("exp_frames_left", 64'(exp_q.size()), 64'(0));
    check("exp_rsp_left", 64'(exp_rsp_q.size()), 64'(0));
    check("end_idle_ready", 64'(cmd_ready), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI initiator that frames 10-bit RAM commands onto SS_n/MOSI and collects 8-bit read data from MISO.
- It is the counterpart of our SPI slave + single-port RAM.
- It sits between a host-side command handshake and the slave's serial pins.
- SPI bit timing is the shared system clock: one bit per clk cycle, no separate SCLK.

Parameters:
- RD_LAT, default 2: clk cycles between the last MOSI bit of a read-data frame and the first valid MISO bit (range 0..15).
- GAP, default 1: minimum SS_n-high cycles between frames (range 1..15).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  host presents a command.
- cmd_ready  output  1  block can accept a command; high only in IDLE.
- cmd_op  input  2  opcode: 00 write addr, 01 write data, 10 read addr, 11 read data.
- cmd_data  input  8  address/data payload.
- SS_n  output  1  slave select, active low.
- MOSI  output  1  serial data to slave.
- MISO  input  1  serial data from slave.
- rsp_valid  output  1  one-cycle pulse when read data is available.
- rsp_data  output  8  read byte; holds its value until the next read completes.
- busy  output  1  high whenever not in IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - SS_n=1, MOSI=0, rsp_valid=0, rsp_data=0, busy=0, cmd_ready=1.
  - All counters and shift registers are cleared.
  - Reset mid-frame aborts immediately: SS_n rises asynchronously and no rsp_valid is produced.
- Accept:
  - A command is accepted on a clk edge with cmd_valid && cmd_ready.
  - The frame {cmd_op, cmd_data} (10 bits) and the opcode are latched at acceptance.
  - Inputs are ignored while busy.
- States: IDLE, START, CMD, SHIFT, WAIT, RECV, GAP.
- Transitions and outputs per state:
  - IDLE -> START on accept. SS_n=1.
  - START, 1 cycle: SS_n=0, MOSI=0. The slave detects select here. Next state is CMD.
  - CMD, 1 cycle: SS_n=0, MOSI=op[1] (0 = write path, 1 = read path). Next state is SHIFT.
  - SHIFT, 10 cycles: MOSI=frame[9-k] for k=0..9, MSB first. A 4-bit bit counter counts 0..9.
    - If op==11, go to WAIT when RD_LAT>0, else go directly to RECV.
    - Otherwise go to GAP.
  - WAIT, RD_LAT cycles: SS_n=0, MOSI=0. Next state is RECV.
  - RECV, 8 cycles: SS_n=0, MOSI=0. On cycle k, MISO is sampled into rx_shift[k] (LSB first).
    - On the 8th sample, go to GAP.
    - On that same edge, rsp_data <= assembled byte and rsp_valid is asserted for exactly the first GAP cycle.
  - GAP, GAP cycles: SS_n=1, MOSI=0. Next state is IDLE.
- Frame length with SS_n low:
  - 12 cycles for op 00/01/10.
  - 20+RD_LAT cycles for op 11.
- Command-to-command throughput:
  - Write frame: 1 (IDLE) + 12 + GAP cycles.
  - Read-data frame: 1 (IDLE) + 20 + RD_LAT + GAP cycles.
- Protocol ordering is the host's responsibility:
  - read addr (10) must precede read data (11).
  - write addr (00) must precede write data (01).
  - The block does not enforce or reorder commands.
- cmd_valid held high continuously:
  - The next command is accepted on the first IDLE cycle after GAP.
  - Back-to-back IDLE is 1 cycle minimum.
- cmd_ready is combinational from state (IDLE). It never depends on cmd_valid.
- MISO is ignored outside RECV.
- rsp_valid never asserts for op 00/01/10.

Decomposition:
- Package spi_pkg, shared with the slave:
  - opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11.
  - FRAME_W=10, DATA_W=8.
  - State encodings for this block.
- No sub-module is needed.
- A generic down-counter (spi_bit_cnt) is optional but not required.
- The FSM, the 10-bit TX shift register and the 8-bit RX shift register all live in one module.

Test Plan:
- Reset mid-read: assert rst_n=0 during RECV bit 3 -> SS_n=1 within the same cycle, rsp_valid stays 0, cmd_ready=1 after release.
- Write address: cmd_op=00, cmd_data=0x5A -> SS_n low for exactly 12 cycles.
  - MOSI sequence: 0, 0, then 0,0,0,1,0,1,1,0,1,0.
  - SS_n high for GAP=1 cycle; no rsp_valid.
- Read address then read data (pair with the slave+RAM model, RAM[0x3C]=0xA7):
  - cmd 10/0x3C: CMD bit=1 and 10-bit frame 10_0011_1100.
  - cmd 11/0x00: 22 SS_n-low cycles (RD_LAT=2); rsp_valid pulses once with rsp_data=0xA7.
- LSB-first capture: drive MISO during RECV with 1,0,0,0,0,0,0,1 -> rsp_data=0x81. With RD_LAT=0, the first sample is the cycle right after the last MOSI bit.
- Back-to-back: cmd_valid held high with three write commands -> each accepted exactly once.
  - cmd_ready is low throughout frames.
  - Start of each frame is 14 cycles apart (GAP=1).
- Ignored input: toggle cmd_valid/cmd_data during SHIFT -> MOSI frame unchanged from the latched value, no extra accept.
